seven_segment_display_arbiter: RTL and testbench
================================================

# seven_segment_display_arbiter

Shares the Basys3 4-digit seven-segment display between up to `N_SRC` 16-bit value sources, such as the PC, accumulator, bus address and debug register. The block feeds the 4 hex digits into the multiplexing display driver. Sources are chosen by round-robin, advanced by a button pulse or an auto-rotate timer. Any source may pre-empt the display for a fixed hold time with a flash request.

## Interface
- `N_SRC`, 4: number of sources, 2..8.
- `HOLD_CYCLES`, 100_000_000: flash hold duration in clk cycles (1 s at 100 MHz), ≥2.
- `ROTATE_CYCLES`, 200_000_000: auto-rotate period in clk cycles, ≥2.
- `clk`  in  1: system clock; the only clock.
- `reset`  in  1: synchronous, active-high reset.
- `src_value[N_SRC-1:0]`  in  16 each: per-source display value.
- `src_enable`  in  N_SRC: level; the source is present and selectable.
- `flash_req`  in  N_SRC: single-cycle pulse; request a flash of that source.
- `btn_next`  in  1: single-cycle pulse, already debounced upstream; advance the source.
- `auto_rotate`  in  1: level; enables timed advance.
- `dig[3:0]`  out  4 each: hex digits to the driver; `dig[0]` = value[3:0] (rightmost), `dig[3]` = value[15:12].
- `blank`  out  1: high means the top level forces all anodes off.
- `cur_src`  out  $clog2(N_SRC): index of the currently shown base source.
- `flash_active`  out  1: high while a flash is displayed.
- `flash_ack`  out  N_SRC: one-cycle one-hot pulse to the granted flash requester.

## Operation
- The state machine has three states: BLANK, SHOW and FLASH.
- Reset values: state=BLANK, `cur_src`=0, all `dig`=0, `blank`=1, `flash_active`=0, `flash_ack`=0, both counters=0.
- BLANK:
  - Stays in BLANK while `src_enable`==0.
  - Otherwise, next state is SHOW with `cur_src` = lowest enabled index.
- SHOW:
  - `dig` is registered from `src_value[cur_src]` every cycle, so live values track with 1-cycle latency. `blank`=0.
  - Advance means selecting the next enabled index after `cur_src`, round-robin, wrapping N_SRC-1→0.
  - If the only enabled source is `cur_src`, advance keeps it.
  - Advance triggers: `btn_next`; the rotate counter reaching ROTATE_CYCLES-1 while `auto_rotate`=1; or `src_enable[cur_src]` dropping.
  - The rotate counter clears on any advance and holds at 0 while `auto_rotate`=0.
  - If all enables drop, next state is BLANK; `dig` holds its last value and `blank`=1.
- FLASH entry (from SHOW or BLANK):
  - Masked request = `flash_req & src_enable`. If nonzero, the lowest index wins (fixed priority).
  - Its `src_value` is snapshotted into `dig`.
  - The hold counter clears, `flash_active`=1, `flash_ack[winner]` pulses, `blank`=0.
- FLASH:
  - `dig` holds the snapshot.
  - Exits when the hold counter reaches HOLD_CYCLES-1, or on `btn_next` (early dismiss, no advance).
  - Exit goes to SHOW with `cur_src` unchanged, or to BLANK if no source is enabled.
  - Requests arriving during FLASH are dropped with no ack; requesters retry.
  - The rotate counter is frozen during FLASH.
- Simultaneous events:
  - `flash_req` and `btn_next` in the same SHOW cycle: flash wins and the button is discarded.
  - `btn_next` and rotate expiry in the same cycle: a single advance.
  - Flashed source disabled mid-flash: the flash continues on the snapshot.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Advance triggered at cycle t: the new `cur_src` and its `dig` are visible at t+1.
- `flash_req` at cycle t:
  - `flash_active`=1 and `flash_ack` high at t+1. `flash_ack` is high for exactly 1 cycle.
  - `flash_active` stays high for exactly HOLD_CYCLES cycles, t+1..t+HOLD_CYCLES.
  - SHOW resumes at t+HOLD_CYCLES+1.
- Reset asserted mid-FLASH: outputs return to reset values on the next edge. No ack is issued for a request coincident with reset.
- Counter widths are $clog2 of the respective parameter; counters never wrap except via the clears defined above.

## Structure
- The shared package `seven_segment_pkg` holds:
  - `disp_state_e` {DISP_BLANK, DISP_SHOW, DISP_FLASH};
  - `localparam NUM_DIGITS=4`;
  - `typedef logic [3:0] hex_digit_t`.
- One combinational sub-module, `rr_next_enabled`, has parameter N and ports `mask`, `cur`, `next`, `found`. It implements the round-robin search starting from cur+1 with wrap. The lowest-enabled choice on entry from BLANK reuses it with cur=N-1.

## Test plan
- Reset, enable=4'b0101, values 0x1234/0xABCD on src0/src2 → `blank`=0, `cur_src`=0, `dig`={1,2,3,4}. `btn_next` → `cur_src`=2, `dig`={A,B,C,D} next cycle. `btn_next` again → wraps to 0.
- ROTATE_CYCLES=8, `auto_rotate`=1, enable=4'b1111 → `cur_src` increments every 8 cycles. Enable=4'b0001 → `cur_src` stays at 0.
- In SHOW on src1, `flash_req`=4'b1100 with src3 value 0xBEEF → `flash_ack`=4'b0100 for 1 cycle, `dig` shows src2's snapshot, `flash_active` high for HOLD_CYCLES=16 cycles, then `cur_src`=1 resumes. A second request mid-flash gets no ack.
- `flash_req` and `btn_next` in the same cycle → FLASH entered, `cur_src` unchanged. `btn_next` during FLASH → exit next cycle, no advance.
- Showing src2, `src_enable[2]` drops → `cur_src`=next enabled index. All enables drop → `blank`=1, state BLANK.
- Assert `reset` mid-FLASH → next edge: `flash_active`=0, `blank`=1, `cur_src`=0, `dig` all 0.

Source files
------------

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
package seven_segment_pkg;

  typedef enum logic [1:0] {
    DISP_BLANK,
    DISP_SHOW,
    DISP_FLASH
  } disp_state_e;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [3:0] hex_digit_t;

endpackage

// File: rtl/seven_segment_display_arbiter_rr_next_enabled.sv
// Round-robin search: first set bit of mask strictly after cur, wrapping; cur itself is last.
module rr_next_enabled #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         mask,
  input  logic [$clog2(N)-1:0] cur,
  output logic [$clog2(N)-1:0] next,
  output logic                 found
);

  localparam int unsigned W = $clog2(N);

  always_comb begin
    int idx;
    next  = '0;
    found = 1'b0;
    idx   = 0;
    // Walk from the farthest candidate down so the nearest one is assigned last and wins.
    for (int i = int'(N); i >= 1; i--) begin
      idx = (int'(cur) + i) % int'(N);
      if (mask[idx]) begin
        next  = W'(idx);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_segment_display_arbiter.sv
// Chooses which 16-bit source drives the 4-digit display: round-robin base selection
// with timed or button advance, pre-empted by fixed-duration flash requests.
module seven_segment_display_arbiter
  import seven_segment_pkg::*;
#(
  parameter int unsigned N_SRC         = 4,
  parameter int unsigned HOLD_CYCLES   = 100_000_000,
  parameter int unsigned ROTATE_CYCLES = 200_000_000
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SRC-1:0][15:0]              src_value,
  input  logic [N_SRC-1:0]                    src_enable,
  input  logic [N_SRC-1:0]                    flash_req,
  input  logic                                btn_next,
  input  logic                                auto_rotate,
  output hex_digit_t [NUM_DIGITS-1:0]         dig,
  output logic                                blank,
  output logic [$clog2(N_SRC)-1:0]            cur_src,
  output logic                                flash_active,
  output logic [N_SRC-1:0]                    flash_ack
);

  localparam int unsigned SrcW  = $clog2(N_SRC);
  localparam int unsigned HoldW = $clog2(HOLD_CYCLES);
  localparam int unsigned RotW  = $clog2(ROTATE_CYCLES);

  localparam logic [SrcW-1:0]  LastIdx = SrcW'(N_SRC - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_CYCLES - 1);
  localparam logic [RotW-1:0]  RotMax  = RotW'(ROTATE_CYCLES - 1);

  disp_state_e                 state_q, state_d;
  logic [SrcW-1:0]             cur_q, cur_d;
  hex_digit_t [NUM_DIGITS-1:0] dig_q, dig_d;
  logic                        blank_q, blank_d;
  logic                        flash_q, flash_d;
  logic [N_SRC-1:0]            ack_q, ack_d;
  logic [HoldW-1:0]            hold_q, hold_d;
  logic [RotW-1:0]             rot_q, rot_d;

  logic [N_SRC-1:0] req_masked;
  logic [SrcW-1:0]  adv_idx, low_idx, win_idx;
  logic             adv_found, low_found, win_found;
  logic             advance, enter_flash;

  assign req_masked = flash_req & src_enable;

  rr_next_enabled #(.N(N_SRC)) u_rr_adv (
    .mask  (src_enable),
    .cur   (cur_q),
    .next  (adv_idx),
    .found (adv_found)
  );

  // Starting the search after the last index yields the lowest set bit.
  rr_next_enabled #(.N(N_SRC)) u_rr_low (
    .mask  (src_enable),
    .cur   (LastIdx),
    .next  (low_idx),
    .found (low_found)
  );

  rr_next_enabled #(.N(N_SRC)) u_rr_win (
    .mask  (req_masked),
    .cur   (LastIdx),
    .next  (win_idx),
    .found (win_found)
  );

  assign advance     = btn_next | (auto_rotate & (rot_q == RotMax)) | ~src_enable[cur_q];
  assign enter_flash = win_found & (state_q != DISP_FLASH);

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    dig_d   = dig_q;
    blank_d = blank_q;
    flash_d = 1'b0;
    ack_d   = '0;
    hold_d  = hold_q;
    rot_d   = rot_q;

    unique case (state_q)
      DISP_BLANK: begin
        if (low_found) begin
          state_d = DISP_SHOW;
          cur_d   = low_idx;
          dig_d   = src_value[low_idx];
          blank_d = 1'b0;
          rot_d   = '0;
        end
      end
      DISP_SHOW: begin
        if (!adv_found) begin
          state_d = DISP_BLANK;
          blank_d = 1'b1;
          rot_d   = '0;
        end else if (advance) begin
          cur_d = adv_idx;
          dig_d = src_value[adv_idx];
          rot_d = '0;
        end else begin
          dig_d = src_value[cur_q];
          rot_d = auto_rotate ? rot_q + RotW'(1) : '0;
        end
      end
      DISP_FLASH: begin
        if ((hold_q == HoldMax) || btn_next) begin
          if (low_found) begin
            state_d = DISP_SHOW;
            dig_d   = src_value[cur_q];
            blank_d = 1'b0;
          end else begin
            state_d = DISP_BLANK;
            blank_d = 1'b1;
          end
        end else begin
          flash_d = 1'b1;
          hold_d  = hold_q + HoldW'(1);
        end
      end
      default: state_d = DISP_BLANK;
    endcase

    // Flash pre-empts everything above; base selection and rotate counter stay put.
    if (enter_flash) begin
      state_d        = DISP_FLASH;
      cur_d          = cur_q;
      dig_d          = src_value[win_idx];
      blank_d        = 1'b0;
      flash_d        = 1'b1;
      ack_d[win_idx] = 1'b1;
      hold_d         = '0;
      rot_d          = rot_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= DISP_BLANK;
      cur_q   <= '0;
      dig_q   <= '0;
      blank_q <= 1'b1;
      flash_q <= 1'b0;
      ack_q   <= '0;
      hold_q  <= '0;
      rot_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      dig_q   <= dig_d;
      blank_q <= blank_d;
      flash_q <= flash_d;
      ack_q   <= ack_d;
      hold_q  <= hold_d;
      rot_q   <= rot_d;
    end
  end

  assign dig          = dig_q;
  assign blank        = blank_q;
  assign cur_src      = cur_q;
  assign flash_active = flash_q;
  assign flash_ack    = ack_q;

endmodule

// File: tb/tb_seven_segment_display_arbiter.sv
// Cycle-level scoreboard bench: a behavioural model pushes expected outputs, checked after each edge.
module tb_seven_segment_display_arbiter;

  localparam int NS   = 4;
  localparam int HOLD = 16;
  localparam int ROT  = 8;
  localparam int MB = 0, MS = 1, MF = 2;

  logic             clk;
  logic             reset;
  logic [3:0][15:0] src_value;
  logic [3:0]       src_enable;
  logic [3:0]       flash_req;
  logic             btn_next;
  logic             auto_rotate;
  logic [3:0][3:0]  dig;
  logic             blank;
  logic [1:0]       cur_src;
  logic             flash_active;
  logic [3:0]       flash_ack;

  seven_segment_display_arbiter #(
    .N_SRC         (NS),
    .HOLD_CYCLES   (HOLD),
    .ROTATE_CYCLES (ROT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .src_value    (src_value),
    .src_enable   (src_enable),
    .flash_req    (flash_req),
    .btn_next     (btn_next),
    .auto_rotate  (auto_rotate),
    .dig          (dig),
    .blank        (blank),
    .cur_src      (cur_src),
    .flash_active (flash_active),
    .flash_ack    (flash_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        blank;
    logic [1:0]  cur;
    logic [15:0] dig;
    logic        fa;
    logic [3:0]  ack;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  int          m_state = MB;
  int          m_cur   = 0;
  logic [15:0] m_dig   = '0;
  logic        m_blank = 1'b1;
  logic        m_fa    = 1'b0;
  logic [3:0]  m_ack   = '0;
  int          m_rot   = 0;
  int          m_hold  = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // First set bit of m scanning upward from start with wrap; -1 if none.
  function automatic int first_from(logic [3:0] m, int start);
    for (int k = 0; k < NS; k++) begin
      int j;
      j = (start + k) % NS;
      if (m[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_update();
    int   win;
    logic adv;
    m_ack = '0;
    if (reset) begin
      m_state = MB; m_cur = 0; m_dig = '0; m_blank = 1'b1; m_fa = 1'b0;
      m_rot = 0; m_hold = 0;
      return;
    end
    win = (m_state == MF) ? -1 : first_from(flash_req & src_enable, 0);
    if (win >= 0) begin
      m_state = MF; m_dig = src_value[win]; m_hold = 0; m_fa = 1'b1;
      m_ack[win] = 1'b1; m_blank = 1'b0;
      return;
    end
    case (m_state)
      MB: if (src_enable != 0) begin
        m_state = MS; m_cur = first_from(src_enable, 0); m_dig = src_value[m_cur];
        m_blank = 1'b0; m_rot = 0;
      end
      MS: begin
        if (src_enable == 0) begin
          m_state = MB; m_blank = 1'b1; m_rot = 0;
        end else begin
          adv = btn_next || (auto_rotate && m_rot == ROT - 1) || !src_enable[m_cur];
          if (adv) begin
            m_cur = first_from(src_enable, m_cur + 1); m_rot = 0;
          end else begin
            m_rot = auto_rotate ? m_rot + 1 : 0;
          end
          m_dig = src_value[m_cur];
        end
      end
      default: begin
        if (m_hold == HOLD - 1 || btn_next) begin
          m_fa = 1'b0;
          if (src_enable != 0) begin
            m_state = MS; m_dig = src_value[m_cur]; m_blank = 1'b0;
          end else begin
            m_state = MB; m_blank = 1'b1;
          end
        end else begin
          m_hold++;
        end
      end
    endcase
  endtask

  task automatic step();
    exp_t e, o;
    model_update();
    e.blank = m_blank; e.cur = 2'(m_cur); e.dig = m_dig; e.fa = m_fa; e.ack = m_ack;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    o = sb_q.pop_front();
    check_eq("blank", 32'(blank), 32'(o.blank));
    check_eq("cur_src", 32'(cur_src), 32'(o.cur));
    check_eq("dig", 32'(dig), 32'(o.dig));
    check_eq("flash_active", 32'(flash_active), 32'(o.fa));
    check_eq("flash_ack", 32'(flash_ack), 32'(o.ack));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_btn();
    btn_next = 1'b1; step(); btn_next = 1'b0;
  endtask

  task automatic pulse_flash(logic [3:0] r);
    flash_req = r; step(); flash_req = '0;
  endtask

  task automatic go_to(int target);
    for (int k = 0; k < 8 && m_cur != target; k++) pulse_btn();
    check_eq("go_to", 32'(cur_src), 32'(target));
  endtask

  initial begin
    reset = 1'b1; src_enable = '0; flash_req = '0; btn_next = 1'b0; auto_rotate = 1'b0;
    src_value = '0;
    run(2);
    // Blank and idle after reset
    reset = 1'b0;
    run(2);
    src_value[0] = 16'h1234; src_value[1] = 16'h5678;
    src_value[2] = 16'hABCD; src_value[3] = 16'hBEEF;
    src_enable = 4'b0101;
    run(3);
    pulse_btn(); run(2);
    pulse_btn(); run(2);
    // Live value tracking
    src_value[0] = 16'h4321; run(2);
    // Auto-rotate over all sources, then a single source
    src_enable = 4'b1111; auto_rotate = 1'b1;
    run(40);
    btn_next = 1'b1; run(1); btn_next = 1'b0; run(20);
    src_enable = 4'b0001; run(20);
    auto_rotate = 1'b0; src_enable = 4'b1111; run(2);
    // Flash with fixed priority, snapshot, and dropped mid-flash request
    go_to(1);
    pulse_flash(4'b1100);
    run(3);
    src_value[2] = 16'h0F0F;
    run(2);
    pulse_flash(4'b0001);
    run(HOLD + 3);
    // Flash and button together, then early dismiss
    flash_req = 4'b1000; btn_next = 1'b1; step(); flash_req = '0; btn_next = 1'b0;
    run(3);
    pulse_btn(); run(3);
    // Enable drops while showing, then all drop
    go_to(2);
    src_enable = 4'b1011; run(3);
    src_enable = 4'b0000; run(3);
    pulse_flash(4'b0100); run(2);
    // Flash from blank, disabled mid-flash, exits to blank
    src_enable = 4'b1000; pulse_flash(4'b1000); run(4);
    src_enable = 4'b0000; run(HOLD + 2);
    // Reset mid-flash, coincident request not acked
    src_enable = 4'b1111; run(2);
    pulse_flash(4'b0010); run(4);
    reset = 1'b1; flash_req = 4'b0001; step(); flash_req = '0; reset = 1'b0;
    run(3);
    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      int sel;
      if ($urandom_range(0, 15) == 0) src_enable = 4'($urandom);
      flash_req = ($urandom_range(0, 19) == 0) ? 4'($urandom) : 4'h0;
      btn_next = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 31) == 0) auto_rotate = ~auto_rotate;
      if ($urandom_range(0, 3) == 0) begin
        sel = int'($urandom_range(0, 3));
        src_value[sel] = 16'($urandom);
      end
      step();
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
